// File: rtl/geri_yaz_hakem.sv
// Write-back arbiter: KAYNAK producers, each with a one-entry holding slot,
// share a single register-file write port through a round-robin grant.
module geri_yaz_hakem #(
    parameter int VERI_BIT  = 32,
    parameter int ADRES_BIT = 5,
    parameter int KAYNAK    = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [KAYNAK-1:0]             kaynak_gecerli_i,
    output logic [KAYNAK-1:0]             kaynak_hazir_o,
    input  logic [KAYNAK*ADRES_BIT-1:0]   kaynak_hedef_i,
    input  logic [KAYNAK*VERI_BIT-1:0]    kaynak_veri_i,
    output logic                          yazmaca_yaz_o,
    output logic [ADRES_BIT-1:0]          hedef_yazmaci_o,
    output logic [VERI_BIT-1:0]           yazmac_veri_o,
    output logic                          mesgul_o
);

    localparam int PW = (KAYNAK > 1) ? $clog2(KAYNAK) : 1;

    logic [KAYNAK-1:0]    dolu_q, dolu_d;
    logic [ADRES_BIT-1:0] hedef_q [KAYNAK];
    logic [ADRES_BIT-1:0] hedef_d [KAYNAK];
    logic [VERI_BIT-1:0]  veri_q  [KAYNAK];
    logic [VERI_BIT-1:0]  veri_d  [KAYNAK];
    logic [PW-1:0]        isaretci_q, isaretci_d;
    logic                 yaz_q, yaz_d;
    logic [ADRES_BIT-1:0] cikis_hedef_q, cikis_hedef_d;
    logic [VERI_BIT-1:0]  cikis_veri_q, cikis_veri_d;

    logic                 hibe;
    logic [PW-1:0]        secilen;

    // Round-robin search: first occupied slot starting at the pointer, wrapping.
    // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        hibe    = 1'b0;
        secilen = '0;
        idx     = 0;
        for (int i = 0; i < KAYNAK; i++) begin
            idx = int'(isaretci_q) + i;
            if (idx >= KAYNAK) idx = idx - KAYNAK;
            if (!hibe && dolu_q[idx]) begin
                hibe    = 1'b1;
                secilen = PW'(idx);
            end
        end
    end

    // A slot being drained this cycle can be refilled at the same edge.
    always_comb begin
        for (int k = 0; k < KAYNAK; k++) begin
            kaynak_hazir_o[k] = !rst_i && (!dolu_q[k] || (hibe && secilen == PW'(k)));
        end
    end

    always_comb begin
        dolu_d        = dolu_q;
        hedef_d       = hedef_q;
        veri_d        = veri_q;
        isaretci_d    = isaretci_q;
        yaz_d         = 1'b0;
        cikis_hedef_d = cikis_hedef_q;
        cikis_veri_d  = cikis_veri_q;

        if (hibe) begin
            yaz_d           = (hedef_q[secilen] != '0);
            cikis_hedef_d   = hedef_q[secilen];
            cikis_veri_d    = veri_q[secilen];
            dolu_d[secilen] = 1'b0;
            isaretci_d      = (secilen == PW'(KAYNAK - 1)) ? '0 : secilen + PW'(1);
        end

        for (int k = 0; k < KAYNAK; k++) begin
            if (kaynak_gecerli_i[k] && kaynak_hazir_o[k]) begin
                dolu_d[k]  = 1'b1;
                hedef_d[k] = kaynak_hedef_i[k*ADRES_BIT +: ADRES_BIT];
                veri_d[k]  = kaynak_veri_i[k*VERI_BIT +: VERI_BIT];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dolu_q        <= '0;
            isaretci_q    <= '0;
            yaz_q         <= 1'b0;
            cikis_hedef_q <= '0;
            cikis_veri_q  <= '0;
        end else begin
            dolu_q        <= dolu_d;
            isaretci_q    <= isaretci_d;
            yaz_q         <= yaz_d;
            cikis_hedef_q <= cikis_hedef_d;
            cikis_veri_q  <= cikis_veri_d;
        end
    end

    // NOTE: slot payload is not reset; it is only ever read while its dolu flag is set.
    always_ff @(posedge clk_i) begin
        hedef_q <= hedef_d;
        veri_q  <= veri_d;
    end

    assign yazmaca_yaz_o   = yaz_q;
    assign hedef_yazmaci_o = cikis_hedef_q;
    assign yazmac_veri_o   = cikis_veri_q;
    assign mesgul_o        = |dolu_q;

endmodule

// File: tb/tb_geri_yaz_hakem.sv
// Scoreboard bench: a three-channel arbiter checked against a slot/pointer
// reference model, plus a one-channel 64-bit instance checked as a pass-through.
module tb_geri_yaz_hakem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i;
    logic [2:0]  g3, hz3;
    logic [14:0] rd3;
    logic [95:0] d3;
    logic        yaz3, mes3;
    logic [4:0]  hy3;
    logic [31:0] vo3;

    logic [0:0]  g1, hz1;
    logic [4:0]  rd1;
    logic [63:0] d1;
    logic        yaz1, mes1;
    logic [4:0]  hy1;
    logic [63:0] vo1;

    geri_yaz_hakem #(.VERI_BIT(32), .ADRES_BIT(5), .KAYNAK(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i),
        .kaynak_gecerli_i(g3), .kaynak_hazir_o(hz3),
        .kaynak_hedef_i(rd3), .kaynak_veri_i(d3),
        .yazmaca_yaz_o(yaz3), .hedef_yazmaci_o(hy3),
        .yazmac_veri_o(vo3), .mesgul_o(mes3)
    );

    geri_yaz_hakem #(.VERI_BIT(64), .ADRES_BIT(5), .KAYNAK(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i),
        .kaynak_gecerli_i(g1), .kaynak_hazir_o(hz1),
        .kaynak_hedef_i(rd1), .kaynak_veri_i(d1),
        .yazmaca_yaz_o(yaz1), .hedef_yazmaci_o(hy1),
        .yazmac_veri_o(vo1), .mesgul_o(mes1)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [4:0]  rd;
        logic [63:0] d;
    } wr_t;

    wr_t q3[$];
    wr_t q1[$];

    // Reference model of the three-channel instance: slot contents and pointer.
    bit          m_dolu [3];
    logic [4:0]  m_rd   [3];
    logic [31:0] m_d    [3];
    int          m_ptr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, check ready/busy, and
    // advance the model to the state after the coming rising edge.
    task automatic step(input logic [2:0] v, input logic [14:0] rdp, input logic [95:0] dp, input bit r);
        int         gk;
        logic [2:0] mhz;
        wr_t        e;
        rst_i = r;
        g3    = v;
        rd3   = rdp;
        d3    = dp;
        #1;
        gk = -1;
        for (int i = 0; i < 3; i++) begin
            if (gk < 0 && m_dolu[(m_ptr + i) % 3]) gk = (m_ptr + i) % 3;
        end
        for (int k = 0; k < 3; k++) mhz[k] = !r && (!m_dolu[k] || gk == k);
        check("hazir3", 64'(hz3), 64'(mhz));
        check("mesgul3", 64'(mes3), 64'(m_dolu[0] | m_dolu[1] | m_dolu[2]));
        if (r) begin
            for (int k = 0; k < 3; k++) m_dolu[k] = 1'b0;
            m_ptr = 0;
        end else begin
            if (gk >= 0) begin
                if (m_rd[gk] != 5'd0) begin
                    e.c  = cyc + 1;
                    e.rd = m_rd[gk];
                    e.d  = 64'(m_d[gk]);
                    q3.push_back(e);
                end
                m_dolu[gk] = 1'b0;
                m_ptr      = (gk + 1) % 3;
            end
            for (int k = 0; k < 3; k++) begin
                if (v[k] && mhz[k]) begin
                    m_dolu[k] = 1'b1;
                    m_rd[k]   = rdp[k*5 +: 5];
                    m_d[k]    = dp[k*32 +: 32];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 15'd0, 96'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        wr_t e;
        bit  exp_en;
        if (mon_on) begin
            while (q3.size() > 0 && q3[0].c < cyc) begin
                e = q3.pop_front();
                check("wr3_lost_cycle", 64'(cyc), 64'(e.c));
            end
            exp_en = q3.size() > 0 && q3[0].c == cyc;
            check("wr3_en", 64'(yaz3), 64'(exp_en));
            if (exp_en) begin
                e = q3.pop_front();
                check("wr3_rd", 64'(hy3), 64'(e.rd));
                check("wr3_data", 64'(vo3), e.d);
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        bit  exp_en;
        if (mon_on) begin
            while (q1.size() > 0 && q1[0].c < cyc) begin
                e = q1.pop_front();
                check("wr1_lost_cycle", 64'(cyc), 64'(e.c));
            end
            exp_en = q1.size() > 0 && q1[0].c == cyc;
            check("wr1_en", 64'(yaz1), 64'(exp_en));
            if (exp_en) begin
                e = q1.pop_front();
                check("wr1_rd", 64'(hy1), 64'(e.rd));
                check("wr1_data", vo1, e.d);
            end
        end
    end

    initial begin
        logic [2:0]  v;
        logic [14:0] rdp;
        logic [95:0] dp;
        logic [31:0] tag;
        wr_t         e;

        rst_i = 1'b1;
        g3 = '0; rd3 = '0; d3 = '0;
        g1 = '0; rd1 = '0; d1 = '0;
        for (int k = 0; k < 3; k++) begin
            m_dolu[k] = 1'b0;
            m_rd[k]   = '0;
            m_d[k]    = '0;
        end
        m_ptr = 0;
        @(negedge clk);

        // Reset state
        step(3'b111, 15'h7fff, {3{32'hffff_ffff}}, 1'b1);
        step(3'b000, 15'd0, 96'd0, 1'b1);
        check("rst_yaz3", 64'(yaz3), 64'd0);
        check("rst_hedef3", 64'(hy3), 64'd0);
        check("rst_veri3", 64'(vo3), 64'd0);
        check("rst_yaz1", 64'(yaz1), 64'd0);
        check("rst_hedef1", 64'(hy1), 64'd0);
        check("rst_veri1", vo1, 64'd0);
        check("rst_hazir1", 64'(hz1), 64'd0);
        check("rst_mesgul1", 64'(mes1), 64'd0);
        mon_on = 1'b1;

        // Single result on channel 1
        step(3'b010, {5'd0, 5'd7, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0}, 1'b0);
        idle(3);

        // x0 on channel 2, then a real result right behind it
        step(3'b100, {5'd0, 5'd0, 5'd0}, {32'h0000_1234, 64'd0}, 1'b0);
        step(3'b100, {5'd9, 5'd0, 5'd0}, {32'h0000_5678, 64'd0}, 1'b0);
        idle(3);

        // All slots full, then reset: nothing may be written
        step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC2, 32'hC1, 32'hC0}, 1'b0);
        step(3'b000, 15'd0, 96'd0, 1'b1);
        step(3'b100, {5'd11, 5'd0, 5'd0}, {32'hAB_0002, 64'd0}, 1'b0);
        idle(3);

        // Back-pressure: channels 0 and 2 fill together, channel 2 input changes while held
        step(3'b101, {5'd4, 5'd0, 5'd3}, {32'hBBBB_0002, 32'd0, 32'hAAAA_0000}, 1'b0);
        step(3'b100, {5'd6, 5'd0, 5'd0}, {32'hCCCC_0002, 64'd0}, 1'b0);
        idle(3);

        // Contention: every channel valid every cycle with tagged data
        tag = 32'h100;
        for (int n = 0; n < 30; n++) begin
            step(3'b111, {5'd3, 5'd2, 5'd1}, {tag + 32'd2, tag + 32'd1, tag}, 1'b0);
            tag = tag + 32'd3;
        end
        idle(4);

        // Random traffic, some x0 targets, occasional reset
        for (int n = 0; n < 400; n++) begin
            v = 3'($urandom);
            for (int k = 0; k < 3; k++) begin
                rdp[k*5 +: 5]   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                dp[k*32 +: 32]  = $urandom;
            end
            step(v, rdp, dp, ($urandom_range(0, 99) == 0));
        end
        idle(6);

        // Single-channel 64-bit stream: one result per cycle, two-cycle latency
        for (int n = 0; n < 8; n++) begin
            g1  = 1'b1;
            rd1 = 5'($urandom_range(1, 31));
            d1  = {$urandom, $urandom};
            #1;
            check("hazir1", 64'(hz1), 64'd1);
            e.c  = cyc + 2;
            e.rd = rd1;
            e.d  = d1;
            q1.push_back(e);
            @(negedge clk);
        end
        g1 = 1'b0;
        repeat (4) @(negedge clk);

        check("q3_drained", 64'(q3.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
